// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions that the load/store unit uses.
//   LDST_*            : decoder mem_size codes (the funct3 encoding of loads/stores)
//   lsu_state_t       : load/store sequencer states
//   lsu_is_misaligned : alignment check for a size code and a byte offset
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [0:0] {
        LSU_IDLE,
        LSU_WAIT
    } lsu_state_t;

    // Unknown size codes count as misaligned, so they never reach memory.
    function automatic logic lsu_is_misaligned(input logic [2:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            LDST_B, LDST_BU: mis = 1'b0;
            LDST_H, LDST_HU: mis = off[0];
            LDST_W:          mis = (off != 2'b00);
            default:         mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/riscv_lsu_ctrl_if.sv
// Bundle of the core-side and memory-side signals of the load/store sequencer.
//   master : the sequencer (consumes core controls and memory responses,
//            drives memory requests, stall, load data and trap flags)
//   slave  : the environment (core datapath plus data memory)
interface riscv_lsu_ctrl_if;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        misaligned_o;
    logic        fault_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport master (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        input  mem_rd_i, mem_ready_i,
        output core_rd_o, core_stall_o, misaligned_o, fault_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );

    modport slave (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        output mem_rd_i, mem_ready_i,
        input  core_rd_o, core_stall_o, misaligned_o, fault_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );
endinterface

// File: rtl/riscv_lsu_align.sv
// Combinational lane steering for the load/store unit.
//   size_i : LDST_* size code       off_i : byte offset addr[1:0]
//   we_i   : 1 = store              wd_i  : raw store data (rs2)
//   rd_i   : raw memory read word
//   be_o   : byte enables (all ones for loads)
//   wd_o   : lane-replicated store data
//   rd_o   : sign/zero-extended load data
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        we_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rd_i,
    output logic [3:0]  be_o,
    output logic [31:0] wd_o,
    output logic [31:0] rd_o
);

    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = rd_i[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = rd_byte[off_i];
    assign sel_half = off_i[1] ? rd_i[31:16] : rd_i[15:0];

    always_comb begin
        be_o = 4'b0000;
        wd_o = '0;
        rd_o = '0;
        case (size_i)
            LDST_B, LDST_BU: begin
                be_o = 4'b0001 << off_i;
                wd_o = {4{wd_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                be_o = 4'b0011 << off_i;
                wd_o = {2{wd_i[15:0]}};
            end
            LDST_W: begin
                be_o = 4'b1111;
                wd_o = wd_i;
            end
            default: ;
        endcase
        // Loads fetch the whole word; lane selection happens on the way back.
        if (!we_i) begin
            be_o = 4'b1111;
        end
        case (size_i)
            LDST_B:  rd_o = {{24{sel_byte[7]}}, sel_byte};
            LDST_BU: rd_o = {24'h0, sel_byte};
            LDST_H:  rd_o = {{16{sel_half[15]}}, sel_half};
            LDST_HU: rd_o = {16'h0, sel_half};
            LDST_W:  rd_o = rd_i;
            default: rd_o = '0;
        endcase
    end

endmodule

// File: rtl/riscv_lsu_ctrl.sv
// Load/store sequencer between the core datapath and data memory.
//   clk_i  : core clock        rst_ni : synchronous active-low reset
//   bus    : core controls in, memory request out, memory response in,
//            stall / load data / misaligned / timeout flags out
// A request is issued combinationally from IDLE, then the core is stalled in
// WAIT until mem_ready_i or until TIMEOUT_CYCLES WAIT cycles pass (0 = never).
module riscv_lsu_ctrl
    import riscv_pkg::*;
#(
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    riscv_lsu_ctrl_if.master  bus
);

    localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [3:0]  be_fmt;
    logic [31:0] wd_fmt;
    logic [31:0] rd_fmt;
    logic        misaligned;

    riscv_lsu_align u_align (
        .size_i (bus.core_size_i),
        .off_i  (bus.core_addr_i[1:0]),
        .we_i   (bus.core_we_i),
        .wd_i   (bus.core_wd_i),
        .rd_i   (bus.mem_rd_i),
        .be_o   (be_fmt),
        .wd_o   (wd_fmt),
        .rd_o   (rd_fmt)
    );

    assign misaligned = lsu_is_misaligned(bus.core_size_i, bus.core_addr_i[1:0]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= LSU_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        bus.core_rd_o    = '0;
        bus.core_stall_o = 1'b0;
        bus.misaligned_o = 1'b0;
        bus.fault_o      = 1'b0;
        bus.mem_req_o    = 1'b0;
        bus.mem_we_o     = 1'b0;
        bus.mem_be_o     = '0;
        bus.mem_addr_o   = '0;
        bus.mem_wd_o     = '0;

        case (state_reg)
            LSU_IDLE: begin
                if (bus.core_req_i) begin
                    if (misaligned) begin
                        bus.misaligned_o = 1'b1;
                    end else begin
                        bus.mem_req_o    = 1'b1;
                        bus.mem_we_o     = bus.core_we_i;
                        bus.mem_be_o     = be_fmt;
                        bus.mem_addr_o   = {bus.core_addr_i[31:2], 2'b00};
                        bus.mem_wd_o     = wd_fmt;
                        bus.core_stall_o = 1'b1;
                        state_next       = LSU_WAIT;
                        cnt_next         = '0;
                    end
                end
            end
            LSU_WAIT: begin
                // The core is frozen, so its live inputs still describe the access.
                bus.mem_req_o  = 1'b1;
                bus.mem_we_o   = bus.core_we_i;
                bus.mem_be_o   = be_fmt;
                bus.mem_addr_o = {bus.core_addr_i[31:2], 2'b00};
                bus.mem_wd_o   = wd_fmt;
                if (bus.mem_ready_i) begin
                    bus.core_rd_o = bus.core_we_i ? 32'h0 : rd_fmt;
                    state_next    = LSU_IDLE;
                end else if (TIMEOUT_EN && (cnt_reg == CNT_LAST)) begin
                    bus.fault_o = 1'b1;
                    state_next  = LSU_IDLE;
                end else begin
                    bus.core_stall_o = 1'b1;
                    cnt_next         = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = LSU_IDLE;
        endcase

        // Reset silences every output immediately and drops any pending access.
        if (!rst_ni) begin
            state_next       = LSU_IDLE;
            cnt_next         = '0;
            bus.core_rd_o    = '0;
            bus.core_stall_o = 1'b0;
            bus.misaligned_o = 1'b0;
            bus.fault_o      = 1'b0;
            bus.mem_req_o    = 1'b0;
            bus.mem_we_o     = 1'b0;
            bus.mem_be_o     = '0;
            bus.mem_addr_o   = '0;
            bus.mem_wd_o     = '0;
        end
    end

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// Directed bench for riscv_lsu_ctrl with TIMEOUT_CYCLES = 4.
module tb_riscv_lsu_ctrl;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    riscv_lsu_ctrl_if bus ();

    riscv_lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    task automatic drive_idle();
        @(negedge clk);
        bus.core_req_i  = 1'b0;
        bus.mem_ready_i = 1'b0;
        #1;
        check_vec("idle_mem_req", 32'(bus.mem_req_o), 32'd0);
    endtask

    // One access: request cycle in IDLE, then ready on the ready_at-th WAIT cycle.
    task automatic do_access(input string tag, input logic we, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdraw, input int ready_at,
                             input logic ready_in_idle,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd,
                             input logic [31:0] exp_rd);
        @(negedge clk);
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = we;
        bus.core_size_i = size;
        bus.core_addr_i = addr;
        bus.core_wd_i   = wd;
        bus.mem_rd_i    = rdraw;
        bus.mem_ready_i = ready_in_idle;
        #1;
        check_vec({tag, "_req"},   32'(bus.mem_req_o),  32'd1);
        check_vec({tag, "_stall0"}, 32'(bus.core_stall_o), 32'd1);
        check_vec({tag, "_we"},    32'(bus.mem_we_o),   32'(we));
        check_vec({tag, "_be"},    32'(bus.mem_be_o),   32'(exp_be));
        check_vec({tag, "_addr"},  bus.mem_addr_o,      {addr[31:2], 2'b00});
        check_vec({tag, "_wd"},    bus.mem_wd_o,        exp_wd);
        for (int c = 1; c <= ready_at; c++) begin
            @(negedge clk);
            bus.mem_ready_i = (c == ready_at);
            #1;
            check_vec({tag, "_wreq"}, 32'(bus.mem_req_o), 32'd1);
            if (c < ready_at) begin
                check_vec({tag, "_stall"}, 32'(bus.core_stall_o), 32'd1);
            end else begin
                check_vec({tag, "_stall_end"}, 32'(bus.core_stall_o), 32'd0);
                check_vec({tag, "_rd"},        bus.core_rd_o,        exp_rd);
                check_vec({tag, "_fault"},     32'(bus.fault_o),     32'd0);
            end
        end
    endtask

    task automatic do_misaligned(input string tag, input logic [2:0] size, input logic [31:0] addr);
        @(negedge clk);
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = size;
        bus.core_addr_i = addr;
        bus.mem_ready_i = 1'b0;
        #1;
        check_vec({tag, "_mis"},   32'(bus.misaligned_o), 32'd1);
        check_vec({tag, "_req"},   32'(bus.mem_req_o),    32'd0);
        check_vec({tag, "_stall"}, 32'(bus.core_stall_o), 32'd0);
        @(negedge clk);
        bus.core_req_i = 1'b0;
        #1;
        check_vec({tag, "_mis_off"}, 32'(bus.misaligned_o), 32'd0);
        check_vec({tag, "_idle"},    32'(bus.mem_req_o),    32'd0);
    endtask

    initial begin
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b1;
        bus.core_size_i = LDST_W;
        bus.core_addr_i = 32'h100;
        bus.core_wd_i   = 32'h1111_1111;
        bus.mem_rd_i    = 32'h0;
        bus.mem_ready_i = 1'b0;

        // Reset with an aligned request pending: everything must stay quiet.
        @(negedge clk);
        #1;
        check_vec("rst_mem_req", 32'(bus.mem_req_o),    32'd0);
        check_vec("rst_stall",   32'(bus.core_stall_o), 32'd0);
        check_vec("rst_be",      32'(bus.mem_be_o),     32'd0);
        check_vec("rst_addr",    bus.mem_addr_o,        32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.core_req_i = 1'b0;
        #1;
        check_vec("post_rst_req", 32'(bus.mem_req_o), 32'd0);

        // Store word, ready on the 3rd cycle: stall 1,1,0.
        do_access("sw",  1'b1, LDST_W,  32'h100, 32'hDEADBEEF, 32'h0, 2, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0);
        drive_idle();
        // Byte loads back to back at offset 3, then halfword loads.
        do_access("lb",  1'b0, LDST_B,  32'h203, 32'h0, 32'h8000_0000, 1, 1'b0, 4'b1111, 32'h0, 32'hFFFF_FF80);
        do_access("lbu", 1'b0, LDST_BU, 32'h203, 32'h0, 32'h8000_0000, 1, 1'b0, 4'b1111, 32'h0, 32'h0000_0080);
        do_access("lhu", 1'b0, LDST_HU, 32'h202, 32'h0, 32'hABCD_0000, 1, 1'b0, 4'b1111, 32'h0, 32'h0000_ABCD);
        do_access("lh",  1'b0, LDST_H,  32'h202, 32'h0, 32'h8001_7FFF, 1, 1'b0, 4'b1111, 32'h0, 32'hFFFF_8001);
        do_access("lh0", 1'b0, LDST_H,  32'h200, 32'h0, 32'h8001_7FFF, 1, 1'b0, 4'b1111, 32'h0, 32'h0000_7FFF);
        do_access("lb1", 1'b0, LDST_B,  32'h201, 32'h0, 32'h0000_A500, 1, 1'b0, 4'b1111, 32'h0, 32'hFFFF_FFA5);
        // Ready asserted in the IDLE request cycle is ignored.
        do_access("lw",  1'b0, LDST_W,  32'h204, 32'h0, 32'h1234_5678, 1, 1'b1, 4'b1111, 32'h0, 32'h1234_5678);
        // Stores with lane replication.
        do_access("sh",  1'b1, LDST_H,  32'h102, 32'h0000_1234, 32'hFFFF_FFFF, 1, 1'b0, 4'b1100, 32'h1234_1234, 32'h0);
        do_access("sb",  1'b1, LDST_B,  32'h101, 32'h0000_00A5, 32'h0, 1, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        do_access("sb3", 1'b1, LDST_B,  32'h103, 32'h0000_003C, 32'h0, 1, 1'b0, 4'b1000, 32'h3C3C_3C3C, 32'h0);
        drive_idle();

        do_misaligned("mis_w",   LDST_W,  32'h102);
        do_misaligned("mis_h",   LDST_H,  32'h101);
        do_misaligned("mis_hu",  LDST_HU, 32'h103);
        do_misaligned("mis_011", 3'b011,  32'h100);

        // Timeout: ready never comes, fault on the 4th WAIT cycle.
        @(negedge clk);
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = LDST_W;
        bus.core_addr_i = 32'h300;
        bus.mem_rd_i    = 32'hCAFE_F00D;
        bus.mem_ready_i = 1'b0;
        #1;
        check_vec("to_req", 32'(bus.mem_req_o), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            #1;
            check_vec("to_fault", 32'(bus.fault_o),      (c == 4) ? 32'd1 : 32'd0);
            check_vec("to_stall", 32'(bus.core_stall_o), (c == 4) ? 32'd0 : 32'd1);
        end
        check_vec("to_rd", bus.core_rd_o, 32'h0);
        @(negedge clk);
        bus.core_req_i = 1'b0;
        #1;
        check_vec("to_after_fault", 32'(bus.fault_o),   32'd0);
        check_vec("to_after_req",   32'(bus.mem_req_o), 32'd0);

        // Ready exactly on the 4th WAIT cycle wins over the timeout.
        do_access("edge", 1'b0, LDST_W, 32'h304, 32'h0, 32'h0BAD_CAFE, 4, 1'b0, 4'b1111, 32'h0, 32'h0BAD_CAFE);
        drive_idle();

        // Reset for one cycle during WAIT.
        @(negedge clk);
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = LDST_W;
        bus.core_addr_i = 32'h400;
        #1;
        check_vec("rw_req", 32'(bus.core_stall_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_vec("rw_mem_req", 32'(bus.mem_req_o),    32'd0);
        check_vec("rw_stall",   32'(bus.core_stall_o), 32'd0);
        check_vec("rw_fault",   32'(bus.fault_o),      32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.core_req_i = 1'b0;
        #1;
        check_vec("rw_idle", 32'(bus.mem_req_o), 32'd0);
        do_access("rw_lw", 1'b0, LDST_W, 32'h400, 32'h0, 32'h5A5A_0001, 3, 1'b0, 4'b1111, 32'h0, 32'h5A5A_0001);
        drive_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_lsu_ctrl.md
Name: riscv_lsu_ctrl

Overview:
Load/store sequencer between the core datapath and data memory. It accepts the decoder's memory controls (mem_req/mem_we/mem_size) plus the ALU address and rs2 data. It stalls the core while a memory handshake is outstanding. It generates byte enables and lane-replicated write data, and returns a sign- or zero-extended read word. It also flags misaligned accesses and memory timeouts to the trap logic.

Parameters:
TIMEOUT_CYCLES, 16, max WAIT cycles before fault; 0 disables the timeout.
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived, not overridden).

Ports:
clk_i  in  1  core clock, all state on rising edge
rst_ni  in  1  reset, synchronous, active-low
core_req_i  in  1  decoder mem_req
core_we_i  in  1  decoder mem_we (1 = store)
core_size_i  in  3  decoder mem_size (LDST_B/H/W/BU/HU)
core_addr_i  in  32  byte address from ALU
core_wd_i  in  32  store data (rs2)
core_rd_o  out  32  formatted load data to writeback mux
core_stall_o  out  1  holds PC and blocks register/CSR writes
misaligned_o  out  1  1-cycle misaligned-access flag
fault_o  out  1  1-cycle timeout flag
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_be_o  out  4  byte enables
mem_addr_o  out  32  word address {core_addr_i[31:2],2'b00}
mem_wd_o  out  32  lane-replicated write data
mem_rd_i  in  32  raw memory read word
mem_ready_i  in  1  memory completion, valid only in WAIT

Behaviour:
- Reset: whenever rst_ni=0, all outputs are 0 and the next state is IDLE with the counter cleared. This includes reset asserted during WAIT; the aborted access is dropped without a fault.
- States: IDLE, WAIT (lsu_state_t).
- Alignment check: H/HU is misaligned when addr[0]=1. W is misaligned when addr[1:0]!=0. Any core_size_i outside the five LDST codes is treated as misaligned.
- IDLE, core_req_i=1, aligned: mem_req_o=1 and core_stall_o=1 combinationally in that same cycle; next state WAIT; counter cleared.
- IDLE, core_req_i=1, misaligned: misaligned_o=1, mem_req_o=0, core_stall_o=0; stay IDLE.
- IDLE, core_req_i=0: all outputs 0.
- WAIT: mem_req_o, mem_we_o, mem_be_o, mem_addr_o and mem_wd_o are held from the live core inputs. The core is stalled, so those inputs are stable.
- WAIT, mem_ready_i=1: core_stall_o=0 in this cycle and core_rd_o is valid this cycle (load only; 0 for stores); next state IDLE.
- WAIT, mem_ready_i=0: core_stall_o=1; counter increments.
- Timeout: TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES-1 with mem_ready_i=0 gives fault_o=1, core_stall_o=0, core_rd_o=0, next state IDLE.
- mem_ready_i has priority over timeout in the same cycle.
- Minimum latency: 2 cycles per access (request cycle + ready cycle). mem_ready_i is ignored in IDLE.
- Back-to-back accesses: a new request is accepted in the cycle after the return to IDLE.
- Byte enables and write data, with off = addr[1:0]:
  - B: be = 4'b0001<<off; wd = {4{wd[7:0]}}.
  - H: be = 4'b0011<<off; wd = {2{wd[15:0]}}.
  - W: be = 4'b1111; wd = wd.
  - Loads drive be = 4'b1111.
- Read formatting: B/BU select byte lane off, H/HU select halfword lane addr[1]. B and H sign-extend; BU and HU zero-extend; W passes the word through.

Decomposition:
- riscv_pkg: add typedef enum logic [0:0] lsu_state_t {LSU_IDLE, LSU_WAIT}. Reuse the existing LDST_B/H/W/BU/HU constants. Add a function lsu_is_misaligned(size, addr[1:0]).
- Sub-module riscv_lsu_align (purely combinational) computes mem_be_o, mem_wd_o and core_rd_o from size, offset and data. The FSM and counter stay in the top level.

Test Plan:
- Store W: addr 0x100, wd 0xDEADBEEF, ready in 3rd cycle → stall 1,1,0; be 1111; mem_addr 0x100; wd 0xDEADBEEF; one access.
- Load B vs BU: addr 0x203, mem_rd 0x80_00_00_00 → rd 0xFFFFFF80 for B and 0x00000080 for BU; load HU at 0x202 of 0xABCD0000 → 0x0000ABCD.
- Store H at 0x102, wd 0x1234 → be 1100, wd 0x12341234; store B at 0x101 → be 0010.
- Misaligned: load W at 0x102 → misaligned_o=1 for 1 cycle, mem_req_o=0, stall 0. Same for H at 0x101 and for size 3'b011.
- Timeout: TIMEOUT_CYCLES=4, ready never asserted → fault_o pulses in the 4th WAIT cycle, stall drops, state returns to IDLE. Ready arriving exactly in the 4th cycle → no fault.
- Reset mid-WAIT: rst_ni=0 for 1 cycle during WAIT → all outputs 0, no fault. A following load completes normally.
